// File: rtl/lsb_mem_unit.sv
// lsb_mem_unit: takes one load/store from the LSB at a time and moves it
// byte-serially over the shared byte-wide RAM port once the arbiter grants.
// Load results are sign/zero-extended and broadcast on the CDB.
module lsb_mem_unit #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              flush,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din,
    input  logic              io_buffer_full,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              store_done
);

    typedef enum logic [2:0] {IDLE, WAIT_GNT, LOAD, STORE, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt, cnt_m1;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, ld_q, ld_ext;
    logic [TAG_W-1:0]  tag_q;
    logic [2:0]        nbytes;
    logic              is_store, io_stall, accept;

    assign is_store = op_q[3];
    // size 11 is illegal and falls through to a word access
    assign nbytes   = (op_q[1:0] == 2'b00) ? 3'd1 : (op_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
    // stores to the HCI output ports must wait while its buffer is full
    assign io_stall = is_store && io_buffer_full &&
                      (addr_q == ADDR_W'(32'h30000) || addr_q == ADDR_W'(32'h30004));
    assign accept   = (state == IDLE) && req_valid && !flush;
    assign cnt_m1   = cnt - 3'd1;

    // state register and byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (rdy) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // request latch and little-endian assembly of load bytes (byte i-1 arrives at count i)
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            tag_q  <= '0;
            ld_q   <= '0;
        end else if (rdy) begin
            if (accept) begin
                op_q   <= req_op;
                addr_q <= req_addr;
                data_q <= req_data;
                tag_q  <= req_tag;
                ld_q   <= '0;
            end else if (state == LOAD && cnt != 3'd0) begin
                ld_q[{cnt_m1[1:0], 3'b000} +: 8] <= mem_din;
            end
        end
    end

    // next state; flush only aborts loads, committed stores always run to completion
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:     if (accept) state_nxt = WAIT_GNT;
            WAIT_GNT: begin
                if (flush && !is_store) begin
                    state_nxt = IDLE;
                end else if (bus_gnt && !io_stall) begin
                    state_nxt = is_store ? STORE : LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                if (flush)                state_nxt = IDLE;
                else if (cnt == nbytes)   state_nxt = DONE;
                else                      cnt_nxt   = cnt + 3'd1;
            end
            STORE: begin
                if (cnt == nbytes - 3'd1) state_nxt = DONE;
                else                      cnt_nxt   = cnt + 3'd1;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // extend assembled load bytes to register width
    always_comb begin
        case (op_q[1:0])
            2'b00:   ld_ext = {{(DATA_W-8){~op_q[2] & ld_q[7]}}, ld_q[7:0]};
            2'b01:   ld_ext = {{(DATA_W-16){~op_q[2] & ld_q[15]}}, ld_q[15:0]};
            default: ld_ext = ld_q;
        endcase
    end

    // Moore outputs decoded from state; bus_req also drops while a store is io-stalled
    always_comb begin
        req_ready  = (state == IDLE) && !flush;
        bus_req    = ((state == WAIT_GNT) && !io_stall) || (state == LOAD) || (state == STORE);
        mem_a      = '0;
        mem_dout   = '0;
        mem_wr     = 1'b0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_data   = '0;
        store_done = 1'b0;
        case (state)
            LOAD:  if (cnt < nbytes) mem_a = addr_q + ADDR_W'(cnt);
            STORE: begin
                mem_a    = addr_q + ADDR_W'(cnt);
                mem_wr   = 1'b1;
                mem_dout = data_q[{cnt[1:0], 3'b000} +: 8];
            end
            DONE: begin
                if (is_store) begin
                    store_done = 1'b1;
                end else begin
                    cdb_valid = 1'b1;
                    cdb_tag   = tag_q;
                    cdb_data  = ld_ext;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsb_mem_unit.sv
// tb_lsb_mem_unit: drives directed and random memory ops, plays arbiter and
// byte RAM, and checks each cycle against a latency/byte-order model.
module tb_lsb_mem_unit;

    logic        clk = 1'b0;
    logic        rst, rdy, req_valid, flush, bus_gnt, io_buffer_full;
    logic [3:0]  req_op, req_tag;
    logic [31:0] req_addr, req_data;
    logic [7:0]  mem_din;
    logic        req_ready, bus_req, mem_wr, cdb_valid, store_done;
    logic [31:0] mem_a, cdb_data;
    logic [7:0]  mem_dout;
    logic [3:0]  cdb_tag;

    logic [7:0]  ram [0:65535];
    int          n_chk = 0;
    int          n_fail = 0;

    lsb_mem_unit #(.TAG_W(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .flush(flush), .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .store_done(store_done)
    );

    always #5 clk = ~clk;

    // RAM read port: data one cycle after address; stalls with the rest of the system
    always @(posedge clk) if (rdy) mem_din <= ram[mem_a[15:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_data", cdb_data, 0);
        chk("rst_store_done", store_done, 0);
    endtask

    // One op end to end. k counts active (rdy=1) edges since the granting edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] tag, input int gnt_dly, input int full_cyc,
                          input int flush_k, input int stall_k, input int stall_len);
        int n, t, k, reqcnt, stall_left, full_left;
        logic is_st, stall_type, gnt_pend, granted, aborted, stalled, fin, exp_bus, cdb_exp;
        logic [63:0] acc;
        logic [31:0] a, exp_ld;
        n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        is_st = op[3];
        t = is_st ? n + 1 : n + 2;
        stall_type = is_st && (addr == 32'h30000 || addr == 32'h30004);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            acc = acc | (64'(ram[a[15:0]]) << (8 * i));
        end
        if (!op[2] && acc[8*n-1]) acc = acc - (64'd1 << (8 * n));
        exp_ld = acc[31:0];

        @(negedge clk);
        chk("accept_ready", req_ready, 1);
        req_valid = 1; req_op = op; req_addr = addr; req_data = data; req_tag = tag;
        io_buffer_full = (full_cyc > 0);
        full_left = full_cyc;
        k = 0; reqcnt = 0; stall_left = 0;
        gnt_pend = 0; granted = 0; aborted = 0; stalled = 0; fin = 0;
        for (int s = 0; s < 200 && !fin; s++) begin
            @(negedge clk);
            req_valid = 0;
            if (gnt_pend) begin granted = 1; gnt_pend = 0; k = 1; end
            if (aborted || (granted && k == t + 1)) begin
                chk("end_bus_req", bus_req, 0);
                chk("end_cdb_valid", cdb_valid, 0);
                chk("end_store_done", store_done, 0);
                chk("end_mem_wr", mem_wr, 0);
                flush = 0; bus_gnt = 0;
                #1 chk("end_req_ready", req_ready, 1);
                fin = 1;
            end else begin
                exp_bus = !granted ? !(stall_type && io_buffer_full) : (k < t);
                chk("req_ready", req_ready, 0);
                chk("bus_req", bus_req, exp_bus);
                chk("mem_wr", mem_wr, granted && is_st && k >= 1 && k <= n);
                if (granted && k <= n) begin
                    chk("mem_a", mem_a, addr + 32'(k - 1));
                    if (is_st) chk("mem_dout", mem_dout, (data >> (8 * (k - 1))) & 32'hFF);
                end
                cdb_exp = granted && !is_st && k == t;
                chk("cdb_valid", cdb_valid, cdb_exp);
                chk("store_done", store_done, granted && is_st && k == t);
                if (cdb_exp) begin
                    chk("cdb_tag", cdb_tag, tag);
                    chk("cdb_data", cdb_data, exp_ld);
                end
                // inputs for the next edge
                flush = 0; rdy = 1;
                if (!granted) begin
                    if (bus_req) reqcnt++;
                    if (full_left > 0) full_left--;
                    io_buffer_full = (full_left > 0);
                    bus_gnt = bus_req && (reqcnt > gnt_dly) && !(stall_type && io_buffer_full);
                    gnt_pend = bus_gnt;
                end else begin
                    bus_gnt = bus_req;
                    if (k == stall_k && !stalled) begin stall_left = stall_len; stalled = 1; end
                    if (stall_left > 0) begin rdy = 0; stall_left--; end
                    if (k == flush_k) begin
                        flush = 1;
                        if (!is_st) aborted = 1;
                    end
                    if (mem_wr && rdy) ram[mem_a[15:0]] = mem_dout;
                    if (rdy) k++;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        flush = 0; rdy = 1; bus_gnt = 0; io_buffer_full = 0;
    endtask

    initial begin
        logic [7:0] b2, b3;
        logic [3:0] rop;
        logic [31:0] raddr, rdata;
        int rn, fk, sk;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        rst = 1; rdy = 1; req_valid = 0; flush = 0; bus_gnt = 0; io_buffer_full = 0;
        req_op = 0; req_addr = 0; req_data = 0; req_tag = 0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 0;

        // flush in IDLE blocks acceptance
        @(negedge clk); req_valid = 1; req_op = 4'b0010; flush = 1;
        @(negedge clk); req_valid = 0; flush = 0;
        chk("flush_idle_bus_req", bus_req, 0);

        // directed loads: LW, LB, LBU, LHU
        ram[16'h100] = 8'h11; ram[16'h101] = 8'h22; ram[16'h102] = 8'h33; ram[16'h103] = 8'h84;
        run_op(4'b0010, 32'h100, 0, 4'd5, 0, 0, -1, -1, 0);
        ram[16'h10] = 8'h80;
        run_op(4'b0000, 32'h10, 0, 4'd1, 1, 0, -1, -1, 0);
        run_op(4'b0100, 32'h10, 0, 4'd2, 0, 0, -1, -1, 0);
        ram[16'h20] = 8'hFF; ram[16'h21] = 8'hFF;
        run_op(4'b0101, 32'h20, 0, 4'd3, 0, 0, -1, -1, 0);

        // SH: only the low half is written
        b2 = ram[16'h202]; b3 = ram[16'h203];
        run_op(4'b1001, 32'h200, 32'hDEADBEEF, 0, 0, 0, -1, -1, 0);
        chk("sh_byte0", ram[16'h200], 8'hEF);
        chk("sh_byte1", ram[16'h201], 8'hBE);
        chk("sh_byte2_kept", ram[16'h202], b2);
        chk("sh_byte3_kept", ram[16'h203], b3);

        // SB to io port while the output buffer is full
        run_op(4'b1000, 32'h30000, 32'h5A, 0, 0, 5, -1, -1, 0);
        chk("sb_io_written", ram[16'h0000], 8'h5A);

        // flush: aborts a load at count 2, never a store
        run_op(4'b0010, 32'h140, 0, 4'd7, 0, 0, 3, -1, 0);
        run_op(4'b1010, 32'h300, 32'hCAFEF00D, 0, 0, 0, 2, -1, 0);
        chk("sw_flush_byte3", ram[16'h303], 8'hCA);

        // rdy freeze during LOAD, and a slow grant
        run_op(4'b0010, 32'h100, 0, 4'd9, 0, 0, -1, 2, 3);
        run_op(4'b0010, 32'h180, 0, 4'd4, 4, 0, -1, -1, 0);

        // reset in the middle of a store
        @(negedge clk); req_valid = 1; req_op = 4'b1010; req_addr = 32'h400; req_data = 32'h12345678; bus_gnt = 1;
        @(negedge clk); req_valid = 0;
        @(negedge clk);
        @(negedge clk); chk("mid_store_wr", mem_wr, 1); rst = 1;
        @(negedge clk); bus_gnt = 0; chk_reset(); rst = 0;

        // random ops, including wrap-around addresses and io-port stores
        for (int r = 0; r < 40; r++) begin
            rop = 4'($urandom);
            rn = (rop[1:0] == 2'b00) ? 1 : (rop[1:0] == 2'b01) ? 2 : 4;
            case ($urandom_range(0, 5))
                0:       raddr = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
                1:       raddr = $urandom_range(0, 1) ? 32'h30000 : 32'h30004;
                default: raddr = 32'($urandom_range(0, 65535));
            endcase
            rdata = $urandom;
            fk = -1; sk = -1;
            case ($urandom_range(0, 2))
                0: fk = $urandom_range(1, rop[3] ? rn : rn + 1);
                1: sk = $urandom_range(1, rop[3] ? rn : rn + 1);
                default: ;
            endcase
            run_op(rop, raddr, rdata, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
                   fk, sk, $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsb_mem_unit.md
Name: lsb_mem_unit

Overview:
- Downstream consumer of the load/store buffer.
- Accepts one memory operation at a time from the LSB and arbitrates for the shared byte-wide RAM port.
- Performs byte-serial loads and stores, sign- or zero-extends load data, and broadcasts load results on the CDB.
- Sits between the LSB and the memory arbiter, which is shared with instruction fetch.

Parameters:
TAG_W, 4, ROB tag width (matches tagWidth)
DATA_W, 32, register data width
ADDR_W, 32, byte address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze all state
req_valid  in  1  LSB presents an operation
req_ready  out  1  unit idle, can accept
req_op  in  4  bit3 store, bit2 unsigned, bits[1:0] size (00 B, 01 H, 10 W)
req_addr  in  ADDR_W  effective byte address
req_data  in  DATA_W  store data
req_tag  in  TAG_W  ROB tag of a load
flush  in  1  misprediction clear
bus_req  out  1  request RAM port
bus_gnt  in  1  arbiter grant; held until bus_req drops
mem_a  out  ADDR_W  RAM address
mem_dout  out  8  RAM write byte
mem_wr  out  1  1 = write
mem_din  in  8  RAM read byte (valid 1 cycle after address)
io_buffer_full  in  1  HCI output buffer full
cdb_valid  out  1  load result valid (1-cycle pulse)
cdb_tag  out  TAG_W  load tag
cdb_data  out  DATA_W  extended load value
store_done  out  1  store finished (1-cycle pulse)

Behaviour:
- Reset: state IDLE; req_ready=1; bus_req=0; mem_wr=0; mem_a=0; mem_dout=0; cdb_valid=0; cdb_tag=0; cdb_data=0; store_done=0; byte counter=0.
- rdy=0: no state, counter or output changes. Pulses are held, not repeated.
- Size N = 1, 2 or 4 bytes. req_op bits[1:0]=11 is illegal and is treated as a word.
- Accept: in IDLE, req_valid&req_ready latches op, addr, data and tag; req_ready drops next cycle; next state WAIT_GNT with bus_req=1.
- WAIT_GNT → LOAD or STORE on the cycle bus_gnt=1, counter=0.
- Store stall: a store to addr 0x30000 or 0x30004 while io_buffer_full=1 stays in WAIT_GNT. bus_req drops while stalled.
- LOAD, counter i:
  - i<N: mem_a=addr+i, mem_wr=0.
  - i≥1: byte i-1 = mem_din, little-endian.
  - Occupies N+1 cycles, then DONE.
- STORE, counter i<N: mem_a=addr+i, mem_wr=1, mem_dout=data[8i+7:8i]. Occupies N cycles, then DONE.
- DONE, one cycle:
  - For a load: cdb_valid=1, cdb_tag, cdb_data. cdb_data is sign-extended from bit 8N-1 unless bit2=1, in which case it is zero-extended.
  - For a store: store_done=1.
  - bus_req=0, mem_wr=0. Next state IDLE with req_ready=1.
- Latency from grant: load = N+2 cycles to cdb_valid; store = N+1 cycles to store_done.
- mem_wr is 0 in every state except STORE.
- No request is accepted in DONE; back-to-back ops incur 1 idle cycle.
- flush: a load in WAIT_GNT or LOAD, or reaching DONE, aborts next cycle to IDLE with no cdb_valid. bus_req drops.
- flush never aborts a store (stores are committed); a store completes normally.
- flush in IDLE blocks acceptance that cycle.
- Address wrap: addr+i wraps modulo 2^ADDR_W.
- Misaligned addresses are not trapped; bytes are accessed serially.
- rst mid-operation: immediate return to reset values. A partially written store is not rolled back.

Test Plan:
- LW addr 0x100, RAM bytes 0x11 0x22 0x33 0x84, tag 5 → mem_a 0x100..0x103, cdb_valid 6 cycles after grant with tag 5, data 0x84332211.
- LB addr 0x10, byte 0x80 → cdb_data 0xFFFFFF80; LBU same byte → cdb_data 0x00000080; LHU bytes 0xFF 0xFF → cdb_data 0x0000FFFF.
- SH addr 0x200, data 0xDEADBEEF → writes 0xEF to 0x200 and 0xBE to 0x201 on consecutive cycles with mem_wr=1; store_done 3 cycles after grant; 0xDEAD never written.
- SB to 0x30000 with io_buffer_full=1 for 5 cycles → no write and bus_req=0 while full; write occurs after release; store_done follows.
- LW in progress with flush asserted at counter=2 → no cdb_valid, IDLE next cycle. SW with flush mid-store → all 4 bytes written, store_done asserted.
- rdy low for 3 cycles during LOAD → counter, mem_a and outputs frozen; final cdb_data correct; bus_gnt delayed 4 cycles → bus_req held high, no RAM access until grant.
